// File: rtl/i2c_lcd_text_ctrl_pkg.sv
// Shared types, LCD command codes and small helpers for the LCD text controller.
package lcd_pkg;

  typedef enum logic [3:0] {
    S_PWR_WAIT   = 4'd0,
    S_INIT       = 4'd1,
    S_INIT_WAIT  = 4'd2,
    S_READY      = 4'd3,
    S_ACCEPT     = 4'd4,
    S_CLEAR_WAIT = 4'd5,
    S_SET_ADDR   = 4'd6,
    S_ADDR_WAIT  = 4'd7,
    S_WRITE_CHAR = 4'd8,
    S_CHAR_WAIT  = 4'd9
  } top_state_e;

  typedef enum logic [2:0] {
    P_IDLE = 3'd0,
    P_REQ  = 3'd1,
    P_ACK  = 3'd2,
    P_DONE = 3'd3,
    P_GAP  = 3'd4
  } pacer_state_e;

  localparam logic [7:0] CMD_RESYNC_A  = 8'h33;
  localparam logic [7:0] CMD_RESYNC_B  = 8'h32;
  localparam logic [7:0] CMD_FUNC_4B2L = 8'h28;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_DDRAM     = 8'h80;
  localparam logic [7:0] ROW1_BASE     = 8'h40;
  localparam int         INIT_LEN      = 6;

  // Power-on command ROM; the two resync bytes recover a consumer left mid-nibble.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = CMD_RESYNC_A;
      3'd1:    init_cmd = CMD_RESYNC_B;
      3'd2:    init_cmd = CMD_FUNC_4B2L;
      3'd3:    init_cmd = CMD_DISP_ON;
      3'd4:    init_cmd = CMD_CLEAR;
      3'd5:    init_cmd = CMD_ENTRY;
      default: init_cmd = CMD_ENTRY;
    endcase
  endfunction

  // Set-DDRAM-address command for a visible (row, col) position.
  function automatic logic [7:0] ddram_addr(input logic row, input logic [3:0] col);
    ddram_addr = CMD_DDRAM | (row ? ROW1_BASE : 8'h00) | {4'h0, col};
  endfunction

endpackage

// File: rtl/i2c_lcd_text_ctrl_byte_pacer.sv
// One-byte handshake with the I2C byte sender followed by a settle gap.
module lcd_byte_pacer
  import lcd_pkg::*;
#(
  parameter int GAP_US = 100,
  parameter int CLR_US = 2000,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       i_usec_tick,
  input  logic       i_req,
  input  logic [7:0] i_byte,
  input  logic       i_rs,
  input  logic       i_byte_busy,
  output logic       o_done,
  output logic       o_send,
  output logic       o_rs,
  output logic [7:0] o_send_buffer
);

  localparam logic [CNT_W-1:0] LIM_GAP = CNT_W'(GAP_US);
  localparam logic [CNT_W-1:0] LIM_CLR = CNT_W'(CLR_US);

  pacer_state_e     r_state;
  pacer_state_e     w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_gap_lim;
  logic [7:0]       r_buf;
  logic             r_rs;
  logic             r_send;
  logic             r_done;

  // Clear and home need the long execution gap, everything else the short one.
  always_comb begin
    if (r_buf == CMD_CLEAR || r_buf == CMD_HOME) w_gap_lim = LIM_CLR;
    else                                         w_gap_lim = LIM_GAP;
  end

  // Next-state logic; send is only raised once the consumer is idle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      P_IDLE:  if (i_req)                w_next = P_REQ;  else w_next = P_IDLE;
      P_REQ:   if (!i_byte_busy)         w_next = P_ACK;  else w_next = P_REQ;
      P_ACK:   if (i_byte_busy)          w_next = P_DONE; else w_next = P_ACK;
      P_DONE:  if (!i_byte_busy)         w_next = P_GAP;  else w_next = P_DONE;
      P_GAP:   if (r_cnt >= w_gap_lim)   w_next = P_IDLE; else w_next = P_GAP;
      default: w_next = P_IDLE;
    endcase
  end

  // State, usec gap counter, latched byte and registered handshake outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state <= P_IDLE;
      r_cnt   <= '0;
      r_buf   <= 8'h00;
      r_rs    <= 1'b0;
      r_send  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)  r_cnt <= '0;
      else if (i_usec_tick)   r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == P_IDLE && i_req) begin
        r_buf <= i_byte;
        r_rs  <= i_rs;
      end
      r_send <= (w_next == P_ACK);
      r_done <= (r_state == P_GAP) && (w_next == P_IDLE);
    end
  end

  assign o_done        = r_done;
  assign o_send        = r_send;
  assign o_rs          = r_rs;
  assign o_send_buffer = r_buf;

endmodule

// File: rtl/i2c_lcd_text_ctrl.sv
// HD44780 (4-bit via PCF8574) text sequencer: power-on init, cursor-tracked character writes, clears.
module i2c_lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int PWRUP_US   = 40000,
  parameter int GAP_US     = 100,
  parameter int CLR_US     = 2000,
  parameter int CNT_W      = 16,
  parameter int CLK_PER_US = 100
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [7:0] char_data,
  input  logic       char_row,
  input  logic [3:0] char_col,
  input  logic       clear_req,
  output logic       init_done,
  output logic       busy,
  output logic [7:0] send_buffer,
  output logic       rs,
  output logic       send,
  input  logic       byte_busy
);

  localparam int               PRE_W     = $clog2(CLK_PER_US);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] LIM_PWRUP = CNT_W'(PWRUP_US);
  localparam logic [2:0]       LAST_IDX  = 3'(INIT_LEN - 1);

  top_state_e       r_state;
  top_state_e       w_next;
  logic [PRE_W-1:0] r_pre;
  logic             w_usec_tick;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_idx;
  logic             r_clr_d, r_clr_pend, w_clr_rise, w_take_clr;
  logic [7:0]       r_data;
  logic             r_row, r_cur_row, r_cur_valid;
  logic [3:0]       r_col, r_cur_col;
  logic             r_init_done, r_busy, r_char_ready;
  logic             w_req, w_rs, w_done;
  logic [7:0]       w_byte;

  assign w_usec_tick = (r_pre == PRE_LAST);
  assign w_clr_rise  = clear_req & ~r_clr_d;
  assign w_take_clr  = (r_state == S_READY) & r_clr_pend;

  // Free-running microsecond prescaler shared by power-up and gap timing.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)          r_pre <= '0;
    else if (w_usec_tick) r_pre <= '0;
    else                  r_pre <= r_pre + PRE_W'(1);
  end

  // Top-level sequencing; a pending clear wins over a character request.
  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_byte = 8'h00;
    w_rs   = 1'b0;
    case (r_state)
      S_PWR_WAIT: if (r_cnt >= LIM_PWRUP) w_next = S_INIT; else w_next = S_PWR_WAIT;
      S_INIT: begin
        w_req  = 1'b1;
        w_byte = init_cmd(r_idx);
        w_next = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (w_done) begin
          if (r_idx == LAST_IDX) w_next = S_READY;
          else                   w_next = S_INIT;
        end else begin
          w_next = S_INIT_WAIT;
        end
      end
      S_READY: begin
        if (r_clr_pend) begin
          w_req  = 1'b1;
          w_byte = CMD_CLEAR;
          w_next = S_CLEAR_WAIT;
        end else if (char_valid) begin
          w_next = S_ACCEPT;
        end else begin
          w_next = S_READY;
        end
      end
      S_ACCEPT: begin
        if (!r_cur_valid || char_row != r_cur_row || char_col != r_cur_col) w_next = S_SET_ADDR;
        else                                                                w_next = S_WRITE_CHAR;
      end
      S_SET_ADDR: begin
        w_req  = 1'b1;
        w_byte = ddram_addr(r_row, r_col);
        w_next = S_ADDR_WAIT;
      end
      S_ADDR_WAIT: if (w_done) w_next = S_WRITE_CHAR; else w_next = S_ADDR_WAIT;
      S_WRITE_CHAR: begin
        w_req  = 1'b1;
        w_byte = r_data;
        w_rs   = 1'b1;
        w_next = S_CHAR_WAIT;
      end
      S_CHAR_WAIT, S_CLEAR_WAIT: if (w_done) w_next = S_READY; else w_next = r_state;
      default: w_next = S_PWR_WAIT;
    endcase
  end

  // State register, power-up counter, init index, clear edge capture and status outputs.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state      <= S_PWR_WAIT;
      r_cnt        <= '0;
      r_idx        <= 3'd0;
      r_clr_d      <= 1'b0;
      r_clr_pend   <= 1'b0;
      r_init_done  <= 1'b0;
      r_busy       <= 1'b1;
      r_char_ready <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_usec_tick)  r_cnt <= r_cnt + CNT_W'(1);
      if (r_state == S_INIT_WAIT && w_done) r_idx <= r_idx + 3'd1;
      if (r_state == S_INIT_WAIT && w_done && r_idx == LAST_IDX) r_init_done <= 1'b1;
      r_clr_d      <= clear_req;
      r_clr_pend   <= w_clr_rise | (r_clr_pend & ~w_take_clr);
      r_busy       <= (w_next != S_READY);
      r_char_ready <= (w_next == S_ACCEPT);
    end
  end

  // Request latch and cursor tracking; column 15 invalidates rather than wrapping into hidden DDRAM.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_data      <= 8'h00;
      r_row       <= 1'b0;
      r_col       <= 4'd0;
      r_cur_row   <= 1'b0;
      r_cur_col   <= 4'd0;
      r_cur_valid <= 1'b0;
    end else begin
      if (r_state == S_ACCEPT) begin
        r_data <= char_data;
        r_row  <= char_row;
        r_col  <= char_col;
      end
      if ((r_state == S_INIT_WAIT && w_done && r_idx == LAST_IDX) || w_take_clr) begin
        r_cur_row   <= 1'b0;
        r_cur_col   <= 4'd0;
        r_cur_valid <= 1'b1;
      end else if (r_state == S_CHAR_WAIT && w_done) begin
        if (r_col == 4'd15) begin
          r_cur_valid <= 1'b0;
        end else begin
          r_cur_row   <= r_row;
          r_cur_col   <= r_col + 4'd1;
          r_cur_valid <= 1'b1;
        end
      end
    end
  end

  lcd_byte_pacer #(
    .GAP_US (GAP_US),
    .CLR_US (CLR_US),
    .CNT_W  (CNT_W)
  ) u_pacer (
    .clk           (clk),
    .reset_p       (reset_p),
    .i_usec_tick   (w_usec_tick),
    .i_req         (w_req),
    .i_byte        (w_byte),
    .i_rs          (w_rs),
    .i_byte_busy   (byte_busy),
    .o_done        (w_done),
    .o_send        (send),
    .o_rs          (rs),
    .o_send_buffer (send_buffer)
  );

  assign init_done  = r_init_done;
  assign busy       = r_busy;
  assign char_ready = r_char_ready;

endmodule

// File: tb/tb_i2c_lcd_text_ctrl.sv
// Scoreboard bench for i2c_lcd_text_ctrl with a behavioural byte_busy model.
module tb_i2c_lcd_text_ctrl;

  logic       clk;
  logic       reset_p;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] char_data;
  logic       char_row;
  logic [3:0] char_col;
  logic       clear_req;
  logic       init_done;
  logic       busy;
  logic [7:0] send_buffer;
  logic       rs;
  logic       send;
  logic       byte_busy;

  i2c_lcd_text_ctrl #(
    .PWRUP_US (50),
    .GAP_US   (5),
    .CLR_US   (20)
  ) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .char_data   (char_data),
    .char_row    (char_row),
    .char_col    (char_col),
    .clear_req   (clear_req),
    .init_done   (init_done),
    .busy        (busy),
    .send_buffer (send_buffer),
    .rs          (rs),
    .send        (send),
    .byte_busy   (byte_busy)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Consumer model: busy 3 cycles after send rises, for 200 cycles.
  logic send_q = 1'b0;
  int   bb_cnt = 0;
  always @(posedge clk) begin
    send_q <= send;
    if (send && !send_q)                 bb_cnt <= 1;
    else if (bb_cnt != 0 && bb_cnt < 203) bb_cnt <= bb_cnt + 1;
    else                                  bb_cnt <= 0;
  end
  assign byte_busy = (bb_cnt >= 3 && bb_cnt < 203);

  logic [8:0] sb[$];
  int         rise_cyc[$];
  int         n_pass  = 0;
  int         n_total = 0;
  int         cyc     = 0;
  int         cr_count = 0;
  int         cr_width = 0;
  logic       mon_send_prev = 1'b0;
  logic       mon_cr_prev   = 1'b0;
  int         rel_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic push_init();
    sb.push_back({1'b0, 8'h33});
    sb.push_back({1'b0, 8'h32});
    sb.push_back({1'b0, 8'h28});
    sb.push_back({1'b0, 8'h0C});
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h06});
  endtask

  // addr_exp = 8'h00 means no address byte is expected
  task automatic write_char(input logic row, input logic [3:0] col, input logic [7:0] d,
                            input logic [7:0] addr_exp);
    int k;
    if (addr_exp != 8'h00) sb.push_back({1'b0, addr_exp});
    sb.push_back({1'b1, d});
    @(posedge clk); #1;
    char_valid = 1'b1;
    char_row   = row;
    char_col   = col;
    char_data  = d;
    k = 0;
    while (char_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("char_ready seen", 32'(char_ready), 32'd1);
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  task automatic wait_ready(input string nm, input int budget);
    int k;
    k = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_init(input string nm, input int budget);
    int k;
    k = 0;
    while (init_done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(init_done), 32'd1);
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear_req = 1'b1;
    @(posedge clk); #1 clear_req = 1'b0;
  endtask

  initial begin
    int k;
    reset_p    = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    char_row   = 1'b0;
    char_col   = 4'd0;
    clear_req  = 1'b0;

    fork
      // Monitor: every send rise pops one expected {rs, byte}
      forever begin
        @(negedge clk);
        cyc++;
        if (!reset_p) begin
          if (send && !mon_send_prev) begin
            rise_cyc.push_back(cyc);
            check("send while byte_busy", 32'(byte_busy), 32'd0);
            if (sb.size() == 0) check("unexpected byte", 32'({rs, send_buffer}), 32'h200);
            else                check("byte", 32'({rs, send_buffer}), 32'(sb.pop_front()));
          end
          if (char_ready && !mon_cr_prev) cr_count++;
          if (!char_ready && mon_cr_prev) check("char_ready width", 32'(cr_width), 32'd1);
          cr_width = char_ready ? cr_width + 1 : 0;
        end
        mon_send_prev = send;
        mon_cr_prev   = char_ready;
      end
    join_none

    repeat (3) @(negedge clk);
    check("reset send", 32'(send), 32'd0);
    check("reset rs", 32'(rs), 32'd0);
    check("reset send_buffer", 32'(send_buffer), 32'h00);
    check("reset char_ready", 32'(char_ready), 32'd0);
    check("reset init_done", 32'(init_done), 32'd0);
    check("reset busy", 32'(busy), 32'd1);

    // Init sequence, with a character request held during init that must be ignored
    push_init();
    reset_p    = 1'b0;
    rel_cyc    = cyc;
    char_valid = 1'b1;
    char_data  = 8'h5A;
    repeat (2000) @(negedge clk);
    char_valid = 1'b0;
    k = 0;
    while (sb.size() != 0 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check("init bytes timeout", 32'(k < 20000), 32'd1);
    repeat (500) @(negedge clk);
    check("init_done before last gap", 32'(init_done), 32'd0);
    wait_init("init_done after init", 2000);
    check("init byte count", 32'(rise_cyc.size()), 32'd6);
    if (rise_cyc.size() >= 6) begin
      check("power-up wait", 32'((rise_cyc[0] - rel_cyc) >= 4900), 32'd1);
      check("clear gap 01->06", 32'((rise_cyc[5] - rise_cyc[4]) >= 2000), 32'd1);
    end
    check("char_ready during init", 32'(cr_count), 32'd0);
    check("busy after init", 32'(busy), 32'd0);

    // Cursor-tracked writes
    write_char(1'b0, 4'd0, 8'h41, 8'h00);
    wait_ready("A done", 5000);
    write_char(1'b0, 4'd1, 8'h42, 8'h00);
    wait_ready("B done", 5000);
    write_char(1'b1, 4'd5, 8'h30, 8'hC5);
    wait_ready("30 done", 5000);
    write_char(1'b0, 4'd15, 8'h5A, 8'h8F);
    wait_ready("col15 done", 5000);
    write_char(1'b0, 4'd0, 8'h41, 8'h80);
    wait_ready("after col15 done", 5000);

    // Two clear edges during a write merge into one clear afterwards
    write_char(1'b1, 4'd0, 8'h43, 8'hC0);
    sb.push_back({1'b0, 8'h01});
    pulse_clear();
    pulse_clear();
    wait_ready("merged clear done", 8000);
    write_char(1'b0, 4'd0, 8'h44, 8'h00);
    wait_ready("write after clear", 5000);
    check("char_ready count", 32'(cr_count), 32'd7);

    // Reset while send is high
    write_char(1'b0, 4'd1, 8'h45, 8'h00);
    k = 0;
    while (send !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("send before reset", 32'(send), 32'd1);
    @(posedge clk); #2;
    reset_p = 1'b1;
    #1;
    check("async send drop", 32'(send), 32'd0);
    check("busy in reset", 32'(busy), 32'd1);
    check("init_done in reset", 32'(init_done), 32'd0);
    check("queue drained before reset", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (10) @(negedge clk);
    push_init();
    reset_p = 1'b0;
    wait_init("re-init done", 20000);
    check("re-init bytes", 32'(sb.size()), 32'd0);

    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
